ram_16x8: RTL and testbench

16-word × 8-bit RAM stage that sits directly downstream of the memory address register and consumes its 4-bit address output. It supports three write sources:
- bus writes in run mode;
- debounced write-button writes from the data dipswitches in program mode;
- a hardware wipe sweep that zeroes all words.

It drives the shared bus on request and provides an always-on data output for the front-panel LEDs.

---
 rtl/ram_16x8_if.sv | 32 +++
 rtl/ram_16x8.sv | 109 ++++++++++
 tb/tb_ram_16x8.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ram_16x8_if.sv
// Bus-side port group of the 16x8 RAM stage: MAR address, bus write data/strobe and read-out paths.
// No latency of its own; this is just the signal bundle.
// No backpressure: load/enable are single-cycle level controls.
interface ram_16x8_if;
    logic [3:0] addr;
    logic [7:0] bus_in;
    logic       load;
    logic       enable;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] data_out;

    modport master (
        output addr,
        output bus_in,
        output load,
        output enable,
        input  bus_out,
        input  bus_oe,
        input  data_out
    );

    modport slave (
        input  addr,
        input  bus_in,
        input  load,
        input  enable,
        output bus_out,
        output bus_oe,
        output data_out
    );
endinterface

// File: rtl/ram_16x8.sv
// 16x8 RAM stage: bus writes (run), debounced dipswitch writes (program), hardware wipe sweep.
// Reads are combinational; writes land on the clock edge; wipe takes 16 edges after it is seen.
// No backpressure: colliding lower-priority writes are dropped, never queued.
module ram_16x8 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clear,
    ram_16x8_if.slave  mbus,
    input  logic       prog_mode,
    input  logic [7:0] prog_data,
    input  logic       prog_write_btn,
    input  logic       wipe,
    output logic       busy
);

    localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] DB_ARM = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] ptr;
    logic       btn_meta;
    logic       btn_sync;
    logic [7:0] cnt;
    logic       wr_pulse;
    logic [7:0] mem [16];
    logic [7:0] rd_dat;
    logic       oe;

    assign rd_dat        = mem[mbus.addr];
    assign oe            = mbus.enable & ~prog_mode & ~busy;
    assign mbus.data_out = rd_dat;
    assign mbus.bus_oe   = oe;
    assign mbus.bus_out  = oe ? rd_dat : 8'h00;

    // Button: two-flop synchronizer, then a saturating run-length counter.
    // The pulse fires only on the N-1 -> N step, so a held button writes once.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            cnt      <= 8'd0;
            wr_pulse <= 1'b0;
        end else begin
            btn_meta <= prog_write_btn;
            btn_sync <= btn_meta;
            wr_pulse <= btn_sync && (cnt == DB_ARM);
            if (!btn_sync) begin
                cnt <= 8'd0;
            end else if (cnt != DB_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Wipe sequencer; busy is registered alongside the state so it equals (state == SWEEP).
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            ptr   <= 4'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wipe) begin
                        state <= SWEEP;
                        ptr   <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    ptr <= ptr + 4'd1;
                    if (ptr == 4'd15) begin
                        state <= HOLD;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    // Wait for wipe to drop so a held request yields a single sweep.
                    if (!wipe) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately unreset so contents survive clear.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr] <= 8'h00;
        end else if (wr_pulse && prog_mode) begin
            mem[mbus.addr] <= prog_data;
        end else if (mbus.load && !prog_mode) begin
            mem[mbus.addr] <= mbus.bus_in;
        end
    end

endmodule

// File: tb/tb_ram_16x8.sv
// Directed self-checking bench for ram_16x8 (DEBOUNCE_CYCLES = 4).
module tb_ram_16x8;

    logic       clk;
    logic       clear;
    logic       prog_mode;
    logic [7:0] prog_data;
    logic       prog_write_btn;
    logic       wipe;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ram_16x8_if mif ();

    ram_16x8 #(.DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .clear         (clear),
        .mbus          (mif),
        .prog_mode     (prog_mode),
        .prog_data     (prog_data),
        .prog_write_btn(prog_write_btn),
        .wipe          (wipe),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        mif.addr   = a;
        mif.bus_in = d;
        mif.load   = 1'b1;
        tick(1);
        mif.load   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        mif.addr = a;
        #1;
        check(tag, mif.data_out, exp);
    endtask

    initial begin
        int nbusy;
        clear          = 1'b0;
        prog_mode      = 1'b0;
        prog_data      = 8'h00;
        prog_write_btn = 1'b0;
        wipe           = 1'b0;
        mif.addr       = 4'd0;
        mif.bus_in     = 8'h00;
        mif.load       = 1'b0;
        mif.enable     = 1'b0;
        #12;
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_oe", {7'd0, mif.bus_oe}, 8'h00);
        check("rst_bus_out", mif.bus_out, 8'h00);
        clear = 1'b1;
        tick(1);

        for (int k = 0; k < 16; k++) bus_write(4'(k), 8'hA0 | 8'(k));
        read_check("pat_w2", 4'd2, 8'hA2);
        read_check("pat_w15", 4'd15, 8'hAF);

        // Wipe held 40 cycles, with a colliding bus load mid-sweep at addr 2.
        mif.enable = 1'b1;
        wipe       = 1'b1;
        nbusy      = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (busy) nbusy++;
            if (i == 4) begin
                mif.addr   = 4'd2;
                mif.bus_in = 8'h11;
                mif.load   = 1'b1;
            end
            if (i == 5) check("oe_during_sweep", {7'd0, mif.bus_oe}, 8'h00);
            if (i == 10) mif.load = 1'b0;
        end
        check("busy_cycles", 8'(nbusy), 8'd16);
        check("busy_after_hold", {7'd0, busy}, 8'h00);
        wipe       = 1'b0;
        mif.enable = 1'b0;
        tick(2);
        for (int k = 0; k < 16; k++) read_check($sformatf("wipe_w%0d", k), 4'(k), 8'h00);

        // Run-mode bus write and read-out gating.
        bus_write(4'd3, 8'hA5);
        check("bus_wr_data_out", mif.data_out, 8'hA5);
        mif.enable = 1'b1;
        #1;
        check("run_oe", {7'd0, mif.bus_oe}, 8'h01);
        check("run_bus_out", mif.bus_out, 8'hA5);
        prog_mode = 1'b1;
        #1;
        check("prog_oe", {7'd0, mif.bus_oe}, 8'h00);
        check("prog_bus_out", mif.bus_out, 8'h00);
        mif.enable = 1'b0;

        // Program mode: short press is ignored, long press writes once at edge 7.
        mif.addr  = 4'd7;
        prog_data = 8'h99;
        prog_write_btn = 1'b1;
        tick(3);
        prog_write_btn = 1'b0;
        tick(10);
        check("short_press", mif.data_out, 8'h00);
        prog_write_btn = 1'b1;
        tick(6);
        check("press_edge6", mif.data_out, 8'h00);
        prog_data = 8'h3C;
        tick(1);
        check("press_edge7", mif.data_out, 8'h3C);
        prog_data = 8'h77;
        tick(13);
        check("press_held_once", mif.data_out, 8'h3C);
        prog_write_btn = 1'b0;
        tick(4);

        // Bounce 1,0,1,0 then steady: steady run starts at the fifth edge, write 6 edges later.
        prog_data = 8'h42;
        prog_write_btn = 1'b1; tick(1);
        prog_write_btn = 1'b0; tick(1);
        prog_write_btn = 1'b1; tick(1);
        prog_write_btn = 1'b0; tick(1);
        prog_write_btn = 1'b1; tick(1);
        tick(5);
        check("bounce_before", mif.data_out, 8'h3C);
        tick(1);
        check("bounce_write", mif.data_out, 8'h42);
        prog_data = 8'h43;
        tick(8);
        check("bounce_once", mif.data_out, 8'h42);
        prog_write_btn = 1'b0;
        tick(3);
        prog_data = 8'hFF;
        prog_write_btn = 1'b1;
        tick(10);
        check("second_press", mif.data_out, 8'hFF);
        prog_write_btn = 1'b0;
        tick(3);

        // Run mode: button pulse coincides with a bus load; the bus write must win.
        prog_mode = 1'b0;
        prog_write_btn = 1'b1;
        tick(6);
        mif.addr   = 4'd7;
        mif.bus_in = 8'h66;
        mif.load   = 1'b1;
        tick(1);
        mif.load   = 1'b0;
        check("load_vs_pulse", mif.data_out, 8'h66);
        tick(3);
        check("run_pulse_discarded", mif.data_out, 8'h66);
        prog_write_btn = 1'b0;
        tick(3);

        // clear asserted just before sweep edge 8.
        for (int k = 0; k < 16; k++) bus_write(4'(k), 8'hA0 | 8'(k));
        wipe = 1'b1;
        tick(1);
        tick(7);
        clear = 1'b0;
        #1;
        check("clear_busy", {7'd0, busy}, 8'h00);
        mif.enable = 1'b1;
        #1;
        check("clear_oe", {7'd0, mif.bus_oe}, 8'h01);
        wipe = 1'b0;
        tick(2);
        clear = 1'b1;
        tick(3);
        check("post_clear_idle", {7'd0, busy}, 8'h00);
        mif.enable = 1'b0;
        for (int k = 0; k < 16; k++)
            read_check($sformatf("abort_w%0d", k), 4'(k), (k < 7) ? 8'h00 : (8'hA0 | 8'(k)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
